seven_seg_rx: RTL and testbench

Receive-side decoder for the multiplexed two-digit seven-segment bus driven by the display controller.
- Samples the 8-bit segment/digit-select bus and waits for each digit to settle.
- Maps each segment glyph back to its hex nibble and reassembles the byte.
- Delivers the byte on a valid/ready interface, once per change in displayed value.
- Used for on-board loopback checking and as a bench monitor for the display path.

---
 rtl/seven_seg_rx.sv | 153 +++++++++++++++
 tb/tb_seven_seg_rx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_rx.sv
// Receive-side decoder for a multiplexed two-digit seven-segment bus.
// Waits for each digit to settle, maps glyphs back to nibbles and hands out each changed byte.
`timescale 1ns/1ps
module seven_seg_rx #(
   parameter int unsigned SETTLE_CYCLES = 16,
   parameter int unsigned TIMEOUT       = 4096
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] seg_in,
   output logic [7:0] dout,
   output logic       dout_valid,
   input  logic       dout_ready,
   output logic       glyph_err,
   output logic       overrun,
   output logic       link_ok
);

   localparam int unsigned     TO_W     = $clog2(TIMEOUT);
   localparam logic [7:0]      STAB_MAX = 8'(SETTLE_CYCLES);
   localparam logic [7:0]      STAB_HIT = 8'(SETTLE_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_HIT   = TO_W'(TIMEOUT - 1);

   typedef enum logic {WAIT_MSB, WAIT_LSB} state_t;

   // {valid, nibble} for an active-high gfedcba pattern
   function automatic logic [4:0] glyph_decode(input logic [6:0] seg);
      logic [4:0] r;
      case (seg)
         7'h3F: r = 5'h10;  7'h06: r = 5'h11;  7'h5B: r = 5'h12;  7'h4F: r = 5'h13;
         7'h66: r = 5'h14;  7'h6D: r = 5'h15;  7'h7D: r = 5'h16;  7'h07: r = 5'h17;
         7'h7F: r = 5'h18;  7'h6F: r = 5'h19;  7'h77: r = 5'h1A;  7'h7C: r = 5'h1B;
         7'h39: r = 5'h1C;  7'h5E: r = 5'h1D;  7'h79: r = 5'h1E;  7'h71: r = 5'h1F;
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   logic [7:0]      seg_p0, seg_p1, seg_p2;
   logic [7:0]      stab_cnt_p2;
   logic            vld_p2;
   logic [TO_W-1:0] to_cnt;
   state_t          state_q, state_d;
   logic [3:0]      hi;
   logic [7:0]      last;
   logic            have_last;
   logic [4:0]      glyph;
   logic [7:0]      byte_c;
   logic            hi_load, pair_done, load_c, err_c, timeout_c;

   // Stage p0/p1: two-flop synchroniser; p2: previous sample plus stability counter
   always_ff @(posedge CLK) begin
      if (RST) begin
         seg_p0      <= 8'hFF;
         seg_p1      <= 8'hFF;
         seg_p2      <= 8'hFF;
         stab_cnt_p2 <= 8'd0;
      end else begin
         seg_p0 <= seg_in;
         seg_p1 <= seg_p0;
         seg_p2 <= seg_p1;
         if (seg_p1 != seg_p2)
            stab_cnt_p2 <= 8'd0;
         else if (stab_cnt_p2 != STAB_MAX)
            stab_cnt_p2 <= stab_cnt_p2 + 8'd1;
      end
   end

   // seg_p2 has been stable for SETTLE_CYCLES samples whenever the counter hits this value
   assign vld_p2 = (stab_cnt_p2 == STAB_HIT);
   assign glyph  = glyph_decode(~seg_p2[6:0]);
   assign byte_c = {hi, glyph[3:0]};

   always_comb begin
      state_d   = state_q;
      hi_load   = 1'b0;
      pair_done = 1'b0;
      load_c    = 1'b0;
      err_c     = 1'b0;
      timeout_c = !vld_p2 && (to_cnt == TO_HIT);
      if (vld_p2) begin
         if (!glyph[4]) begin
            err_c   = 1'b1;
            state_d = WAIT_MSB;
         end else begin
            case (state_q)
               WAIT_MSB: begin
                  if (!seg_p2[7]) begin
                     hi_load = 1'b1;
                     state_d = WAIT_LSB;
                  end
               end
               WAIT_LSB: begin
                  if (!seg_p2[7]) begin
                     hi_load = 1'b1;
                  end else begin
                     pair_done = 1'b1;
                     state_d   = WAIT_MSB;
                     load_c    = !have_last || (byte_c != last);
                  end
               end
               default: state_d = WAIT_MSB;
            endcase
         end
      end else if (timeout_c) begin
         state_d = WAIT_MSB;
      end
   end

   // Stage p3: byte assembly, delivery handshake and link supervision
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= WAIT_MSB;
         to_cnt     <= '0;
         have_last  <= 1'b0;
         link_ok    <= 1'b0;
         dout       <= 8'd0;
         dout_valid <= 1'b0;
         glyph_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state_q   <= state_d;
         glyph_err <= err_c;
         overrun   <= load_c && dout_valid && !dout_ready;
         if (vld_p2)
            to_cnt <= '0;
         else if (to_cnt != TO_HIT)
            to_cnt <= to_cnt + 1'b1;
         if (pair_done) begin
            have_last <= 1'b1;
            link_ok   <= 1'b1;
         end else if (timeout_c) begin
            have_last <= 1'b0;
            link_ok   <= 1'b0;
         end
         if (load_c) begin
            dout       <= byte_c;
            dout_valid <= 1'b1;
         end else if (dout_ready) begin
            dout_valid <= 1'b0;
         end
      end
   end

   // Nibble and last-byte holders are data only; have_last and the FSM qualify them
   always_ff @(posedge CLK) begin
      if (hi_load)
         hi <= glyph[3:0];
      if (pair_done)
         last <= byte_c;
   end

endmodule

// File: tb/tb_seven_seg_rx.sv
// Scoreboard bench for seven_seg_rx: expected bytes queued when digits are driven,
// popped on each dout handshake; pulse outputs tallied by a negedge monitor.
`timescale 1ns/1ps
module tb_seven_seg_rx;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] seg_in;
   logic [7:0] dout;
   logic       dout_valid;
   logic       dout_ready;
   logic       glyph_err;
   logic       overrun;
   logic       link_ok;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] sb[$];
   int         n_rise = 0;
   int         n_gerr = 0;
   int         n_ovr  = 0;
   logic       vld_d  = 1'b0;

   always #5 CLK = ~CLK;

   seven_seg_rx #(.SETTLE_CYCLES(16), .TIMEOUT(4096)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .seg_in     (seg_in),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .glyph_err  (glyph_err),
      .overrun    (overrun),
      .link_ok    (link_ok)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Output monitor, sampled mid-cycle
   always @(negedge CLK) begin
      if (RST) begin
         vld_d <= 1'b0;
      end else begin
         if (dout_valid && !vld_d) n_rise <= n_rise + 1;
         if (glyph_err)            n_gerr <= n_gerr + 1;
         if (overrun)              n_ovr  <= n_ovr + 1;
         if (dout_valid && dout_ready) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) check("sb_byte", {24'd0, dout}, {24'd0, sb.pop_front()});
         end
         vld_d <= dout_valid;
      end
   end

   task automatic hold(input logic [7:0] v, input int n);
      seg_in = v;
      repeat (n) @(posedge CLK);
      #1;
   endtask

   initial begin
      int lat;
      int r0, g0, o0;
      RST        = 1'b1;
      seg_in     = 8'h30;
      dout_ready = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_dout",   {24'd0, dout}, 32'h0);
      check("rst_valid",  dout_valid, 0);
      check("rst_link",   link_ok, 0);
      check("rst_gerr",   glyph_err, 0);
      check("rst_ovr",    overrun, 0);
      RST = 1'b0;

      // First pair: latency and one-cycle delivery
      r0 = n_rise;
      hold(8'h30, 1024);
      sb.push_back(8'h3A);
      seg_in = 8'h88;
      lat = 50;
      for (int i = 1; i <= 50; i++) begin
         @(posedge CLK);
         #1;
         if (dout_valid) begin
            lat = i;
            break;
         end
      end
      check("latency",   lat, 19);
      check("dout_3A",   {24'd0, dout}, 32'h3A);
      @(posedge CLK);
      #1;
      check("valid_1cyc", dout_valid, 0);
      check("link_up",    link_ok, 1);
      hold(8'h88, 1000);
      check("no_gerr_start", n_gerr, 0);

      // Repeated identical frames deliver nothing new
      for (int f = 0; f < 10; f++) begin
         hold(8'h30, 1024);
         hold(8'h88, 1024);
      end
      check("no_dup", n_rise - r0, 1);
      hold(8'h30, 1024);
      sb.push_back(8'h3E);
      hold(8'h86, 1024);
      check("new_3E", n_rise - r0, 2);

      // Short glitch in the LSB window
      hold(8'h30, 1024);
      r0 = n_rise;
      g0 = n_gerr;
      hold(8'h88, 10);
      hold(8'h30, 1024);
      check("glitch_rise", n_rise - r0, 0);
      check("glitch_gerr", n_gerr - g0, 0);

      // Blank glyph: error and return to WAIT_MSB (a lone LSB is then ignored)
      hold(8'hFF, 1024);
      check("blank_gerr", n_gerr - g0, 1);
      check("blank_rise", n_rise - r0, 0);
      hold(8'h88, 1024);
      check("lone_lsb", n_rise - r0, 0);
      sb.push_back(8'h3A);
      hold(8'h30, 1024);
      hold(8'h88, 1024);
      check("after_err", n_rise - r0, 1);

      // Overrun with consumer stalled
      dout_ready = 1'b0;
      o0 = n_ovr;
      hold(8'h30, 1024);
      hold(8'h86, 1024);
      check("stall_valid", dout_valid, 1);
      hold(8'h30, 1024);
      sb.push_back(8'h3A);
      hold(8'h88, 1024);
      check("ovr_pulse",  n_ovr - o0, 1);
      check("ovr_dout",   {24'd0, dout}, 32'h3A);
      check("ovr_valid",  dout_valid, 1);
      dout_ready = 1'b1;
      @(posedge CLK);
      #1;
      check("ready_drop", dout_valid, 0);

      // Link timeout then redelivery of the same byte
      hold(8'h88, 4200);
      check("timeout_link", link_ok, 0);
      r0 = n_rise;
      sb.push_back(8'h3A);
      hold(8'h30, 1024);
      hold(8'h88, 1024);
      check("redeliver", n_rise - r0, 1);
      check("relink",    link_ok, 1);

      // Reset in WAIT_LSB with a pending byte
      dout_ready = 1'b0;
      hold(8'h30, 1024);
      hold(8'h86, 1024);
      hold(8'h30, 1024);
      check("pending", dout_valid, 1);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      check("mid_rst_dout",  {24'd0, dout}, 32'h0);
      check("mid_rst_valid", dout_valid, 0);
      check("mid_rst_link",  link_ok, 0);
      check("mid_rst_gerr",  glyph_err, 0);
      check("mid_rst_ovr",   overrun, 0);
      RST        = 1'b0;
      dout_ready = 1'b1;
      r0 = n_rise;
      sb.push_back(8'h3A);
      hold(8'h30, 1024);
      hold(8'h88, 1024);
      check("post_rst", n_rise - r0, 1);
      check("sb_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
